// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: branch-mode and control-state encodings shared by the fetch unit
package inst_fetch_pkg;
  typedef enum logic [2:0] {
    BR_FWD  = 3'b000,
    BR_BWD  = 3'b001,
    BR_ABS  = 3'b010,
    BR_CALL = 3'b011,
    BR_RET  = 3'b100
  } br_mode_e;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: return-address LIFO; caller guarantees no push when full and no pop when empty
module ret_stack #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] top_idx;
  // occupancy moves by one on push or pop; entries themselves are never cleared
  always_comb begin
    cnt_d   = push_i ? cnt_q + CW'(1) : pop_i ? cnt_q - CW'(1) : cnt_q;
    top_idx = AW'(cnt_q - CW'(1));
  end
  // occupancy register, cleared by reset
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  // storage array, written at the next free slot
  always_ff @(posedge clk_i)
    if (push_i) mem_q[cnt_q[AW-1:0]] <= data_i;
  assign data_o = mem_q[top_idx];
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/inst_fetch_stack.sv
// inst_fetch_stack: program counter sequencer with relative/absolute branches and call/return stack
module inst_fetch_stack
  import inst_fetch_pkg::*;
#(
  parameter int PC_W      = 11,
  parameter int OFF_W     = 8,
  parameter int DEPTH     = 4,
  parameter int COND_W    = 8,
  parameter int RESET_VEC = 0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Branch_On,
  input  logic [2:0]             Br_Mode,
  input  logic [COND_W-1:0]      Cond_Val,
  input  logic [PC_W-1:0]        Target,
  output logic [PC_W-1:0]        ProgCtr,
  output logic                   Stack_Empty,
  output logic                   Stack_Full,
  output logic                   Fault,
  output logic [$clog2(DEPTH):0] Stk_Cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, off, stk_top;
  logic            taken, push, pop;
  assign pc_inc = pc_q + PC_W'(1);
  assign off    = PC_W'(Target[OFF_W-1:0]);
  assign taken  = Branch_On && (Br_Mode == BR_RET || Cond_Val != '0);
  // next state and PC: fault freezes everything, hold freezes PC, then branch, then increment
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_RUN:
        if (Start) state_d = ST_HOLD;
        else if (!taken) pc_d = pc_inc;
        else case (Br_Mode)
          BR_FWD:  pc_d = pc_q + off;
          BR_BWD:  pc_d = pc_q - off;
          BR_ABS:  pc_d = Target;
          BR_CALL: begin
            state_d = Stack_Full ? ST_FAULT : ST_RUN;
            push    = !Stack_Full;
            pc_d    = Stack_Full ? pc_q : Target;
          end
          BR_RET: begin
            state_d = Stack_Empty ? ST_FAULT : ST_RUN;
            pop     = !Stack_Empty;
            pc_d    = Stack_Empty ? pc_q : stk_top;
          end
          default: pc_d = pc_inc;
        endcase
      ST_HOLD: state_d = Start ? ST_HOLD : ST_RUN;
      default: state_d = ST_FAULT;
    endcase
  end
  // control state and PC registers
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= ST_RUN;
      pc_q    <= PC_W'(RESET_VEC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  ret_stack #(.W(PC_W), .DEPTH(DEPTH)) u_stack (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .push_i (push),
    .pop_i  (pop),
    .data_i (pc_inc),
    .data_o (stk_top),
    .cnt_o  (Stk_Cnt)
  );
  assign ProgCtr     = pc_q;
  assign Stack_Empty = (Stk_Cnt == '0);
  assign Stack_Full  = (Stk_Cnt == CW'(DEPTH));
  assign Fault       = (state_q == ST_FAULT);
endmodule

// File: doc/inst_fetch_stack.md
INST_FETCH_STACK -- requirements
Module: inst_fetch_stack

Interface
REQ-001 SHALL have parameter PC_W, default 11, program counter width in bits.
REQ-002 SHALL have parameter OFF_W, default 8, relative branch offset magnitude width (OFF_W <= PC_W).
REQ-003 SHALL have parameter DEPTH, default 4, return-address stack entries (power of two, >= 2).
REQ-004 SHALL have parameter COND_W, default 8, condition operand width.
REQ-005 SHALL have parameter RESET_VEC, default 0, PC value after reset.
REQ-006 SHALL have port Clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port Start  input  1  hold request; PC frozen while high.
REQ-009 SHALL have port Branch_On  input  1  control-flow request this cycle.
REQ-010 SHALL have port Br_Mode  input  3  000 rel-forward, 001 rel-backward, 010 absolute jump, 011 call, 100 return, others reserved.
REQ-011 SHALL have port Cond_Val  input  COND_W  condition operand; taken when nonzero.
REQ-012 SHALL have port Target  input  PC_W  offset magnitude (low OFF_W bits) or absolute address.
REQ-013 SHALL have port ProgCtr  output  PC_W  registered program counter.
REQ-014 SHALL have ports Stack_Empty, Stack_Full, Fault  output  1 each; Stk_Cnt  output  $clog2(DEPTH)+1  stack occupancy.

Function
REQ-015 Control FSM SHALL have states RUN, HOLD, FAULT; reset enters RUN.
REQ-016 RUN: Start=1 -> HOLD, PC unchanged that edge; HOLD: Start=0 -> RUN, PC unchanged that edge.
REQ-017 FAULT SHALL be left only via Reset; PC, stack, Stk_Cnt frozen in FAULT.
REQ-018 Priority per edge SHALL be Reset > FAULT > Start > taken branch > PC+1.
REQ-019 Branch taken iff Branch_On=1 and Cond_Val!=0, except Br_Mode 100 which ignores Cond_Val; not-taken -> PC+1.
REQ-020 Rel-forward: PC <= PC + zero-extended Target[OFF_W-1:0]; rel-backward: PC <= PC - same value.
REQ-021 Absolute jump: PC <= Target.
REQ-022 Call: push PC+1, PC <= Target, Stk_Cnt+1; call when full -> FAULT, no push, PC unchanged.
REQ-023 Return: pop top, PC <= popped value, Stk_Cnt-1; return when empty -> FAULT, PC unchanged.
REQ-024 Reserved Br_Mode with taken condition SHALL behave as PC+1.
REQ-025 All PC arithmetic SHALL wrap modulo 2^PC_W, no saturation or flag.
REQ-026 ProgCtr SHALL reflect the new PC one rising edge after inputs are sampled (latency 1).
REQ-027 Stack_Empty = (Stk_Cnt==0), Stack_Full = (Stk_Cnt==DEPTH), combinational from registered count; Fault = (state==FAULT).
REQ-028 Start and Branch_On together: branch SHALL be discarded, not deferred.

Reset
REQ-029 Reset SHALL immediately (asynchronously) set ProgCtr=RESET_VEC, Stk_Cnt=0, state=RUN, Fault=0, Stack_Empty=1, Stack_Full=0.
REQ-030 Reset mid-HOLD, mid-FAULT, or with Branch_On asserted SHALL give the same result; stack contents need not be cleared.

Structure
REQ-031 Br_Mode encodings and FSM state encodings SHALL live in shared package inst_fetch_pkg.
REQ-032 The LIFO SHALL be sub-module ret_stack (push, pop, data in/out, count), instantiated once.

Verification
REQ-033 Reset, then 5 cycles idle -> ProgCtr 0,1,2,3,4,5; Stack_Empty=1.
REQ-034 PC=3, rel-forward Target=14, Cond_Val=1 -> PC=17; next rel-backward Target=5 -> 12; Cond_Val=0 -> 13.
REQ-035 PC=0, rel-backward Target=1 -> PC=2047 (wrap); rel-forward Target=1 -> 0.
REQ-036 PC=10, call Target=100 -> PC=100, Stk_Cnt=1; 2 increments then return -> PC=11, Stk_Cnt=0.
REQ-037 Four nested calls then fifth -> Stack_Full=1 then Fault=1, PC frozen over 10 cycles until Reset -> PC=0.
REQ-038 Start=1 with Branch_On=1 for 10 cycles -> PC constant; Start=0 -> resumes PC+1 next edge.
